// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares the single RAM address/data/write port between the CPU
//            core and the DMA/IO requester. Uses a request/grant handshake.
//            There is a one-cycle turnaround between owners, and a
//            round-robin tie-break.
// Options  : ARB_BURST_LIMIT_EN - when defined, an owner that has held the
//            bus for MAX_BURST cycles while the other side waits is forced
//            off the bus for one turnaround.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_done,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   input  logic              dma_req,
   input  logic              dma_done,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   input  logic              dma_we,
   output logic              cpu_gnt,
   output logic              dma_gnt,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic [1:0]        owner
);

   localparam logic [1:0] c_OWNER_NONE = 2'd0;
   localparam logic [1:0] c_OWNER_CPU  = 2'd1;
   localparam logic [1:0] c_OWNER_DMA  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_OWN_CPU = 2'd1,
      ST_OWN_DMA = 2'd2,
      ST_TURN    = 2'd3
   } state_t;

   // Reject out-of-range burst limits at elaboration time
   generate
      if (MAX_BURST < 2 || MAX_BURST > 255) begin : g_bad_max_burst
         $error("mem_bus_arbiter: MAX_BURST must be in 2..255");
      end
   endgenerate

   state_t     r_state;
   logic       r_last_dma;    // 1 when DMA was the most recent owner
   logic       r_cpu_gnt;
   logic       r_dma_gnt;
   logic [1:0] r_owner;

   logic       w_cpu_wins;
   logic       w_dma_wins;
   logic       w_cpu_forced;
   logic       w_dma_forced;
   logic       w_cpu_release;
   logic       w_dma_release;

   // Round-robin: on a tie the side that did not own the bus last wins
   assign w_cpu_wins = cpu_req & (~dma_req | r_last_dma);
   assign w_dma_wins = dma_req & (~cpu_req | ~r_last_dma);

`ifdef ARB_BURST_LIMIT_EN
   localparam int                 c_CNT_W      = $clog2(MAX_BURST);
   localparam logic [c_CNT_W-1:0] c_BURST_LAST = c_CNT_W'(MAX_BURST - 1);

   logic [c_CNT_W-1:0] r_burst_cnt;

   // Count owned cycles; held at zero while unowned so each grant starts fresh
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_burst_cnt <= '0;
      end else if (r_state == ST_IDLE || r_state == ST_TURN) begin
         r_burst_cnt <= '0;
      end else if (r_burst_cnt != c_BURST_LAST) begin
         r_burst_cnt <= r_burst_cnt + 1'b1;
      end
   end

   assign w_cpu_forced = (r_burst_cnt == c_BURST_LAST) & dma_req;
   assign w_dma_forced = (r_burst_cnt == c_BURST_LAST) & cpu_req;
`else
   assign w_cpu_forced = 1'b0;
   assign w_dma_forced = 1'b0;
`endif

   // A done pulse from the non-owner is not part of these terms, so it is ignored
   assign w_cpu_release = cpu_done | ~cpu_req | w_cpu_forced;
   assign w_dma_release = dma_done | ~dma_req | w_dma_forced;

   // Ownership state machine with registered grant and owner outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cpu_gnt  <= 1'b0;
         r_dma_gnt  <= 1'b0;
         r_owner    <= c_OWNER_NONE;
         r_last_dma <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE, ST_TURN: begin
               if (w_cpu_wins) begin
                  r_state    <= ST_OWN_CPU;
                  r_cpu_gnt  <= 1'b1;
                  r_owner    <= c_OWNER_CPU;
                  r_last_dma <= 1'b0;
               end else if (w_dma_wins) begin
                  r_state    <= ST_OWN_DMA;
                  r_dma_gnt  <= 1'b1;
                  r_owner    <= c_OWNER_DMA;
                  r_last_dma <= 1'b1;
               end else begin
                  r_state    <= ST_IDLE;
               end
            end
            ST_OWN_CPU: begin
               if (w_cpu_release) begin
                  r_state   <= ST_TURN;
                  r_cpu_gnt <= 1'b0;
                  r_owner   <= c_OWNER_NONE;
               end
            end
            ST_OWN_DMA: begin
               if (w_dma_release) begin
                  r_state   <= ST_TURN;
                  r_dma_gnt <= 1'b0;
                  r_owner   <= c_OWNER_NONE;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_cpu_gnt <= 1'b0;
               r_dma_gnt <= 1'b0;
               r_owner   <= c_OWNER_NONE;
            end
         endcase
      end
   end

   // RAM port mux driven from the registered owner; unowned bus is all zero
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      case (r_owner)
         c_OWNER_CPU: begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
         end
         c_OWNER_DMA: begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we;
         end
         default: begin
            mem_addr  = '0;
            mem_wdata = '0;
            mem_we    = 1'b0;
         end
      endcase
   end

   assign cpu_gnt = r_cpu_gnt;
   assign dma_gnt = r_dma_gnt;
   assign owner   = r_owner;

endmodule
`default_nettype wire
